// File: rtl/id_stage_pkg.sv
// Shared decode definitions: instruction formats, ALU operation codes,
// RV32I opcodes and the decoded bundle handed from decode to execute.
package id_stage_pkg;

    typedef enum logic [2:0] {
        INST_R = 3'd0,
        INST_I = 3'd1,
        INST_S = 3'd2,
        INST_B = 3'd3,
        INST_U = 3'd4,
        INST_J = 3'd5
    } inst_type_e;

    // LTU/GEU are recent additions; execute must implement them too.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_EQ  = 4'd8,
        ALU_NE  = 4'd9,
        ALU_LT  = 4'd10,
        ALU_GE  = 4'd11,
        ALU_LTU = 4'd12,
        ALU_GEU = 4'd13
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        inst_type_e  inst_type;
        alu_op_e     alu_op;
        logic [31:0] sext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decoder: instruction word in, decoded bundle out.
module id_decode
    import id_stage_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_j;
    logic [31:0] shamt;
    logic legal;
    logic writes;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign shamt  = {27'd0, inst[24:20]};

    // Register/immediate ALU op selection shared by OP and OP-IMM.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_LT;
            3'b011:  arith_op = ALU_LTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    // Opcode/funct decode; illegal encodings collapse to an inert bundle.
    always_comb begin
        dec           = '0;
        dec.rs1       = inst[19:15];
        dec.rs2       = inst[24:20];
        dec.rd        = inst[11:7];
        legal         = 1'b1;
        writes        = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec.alu_op = arith_op(funct3, funct7[5]);
                    writes     = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec.inst_type = INST_I;
                writes        = 1'b1;
                if (funct3 == 3'b001) begin
                    dec.alu_op = ALU_SLL;
                    dec.sext   = shamt;
                    legal      = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    dec.sext   = shamt;
                    legal      = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end else begin
                    dec.alu_op = arith_op(funct3, 1'b0);
                    dec.sext   = imm_i;
                end
            end
            OPC_LOAD: begin
                dec.inst_type = INST_I;
                dec.sext      = imm_i;
                dec.mem_re    = 1'b1;
                dec.mem_size  = funct3;
                writes        = 1'b1;
                legal         = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            end
            OPC_STORE: begin
                dec.inst_type = INST_S;
                dec.sext      = imm_s;
                dec.mem_we    = 1'b1;
                dec.mem_size  = funct3;
                legal         = (funct3[2] == 1'b0) && (funct3 != 3'b011);
            end
            OPC_BRANCH: begin
                dec.inst_type = INST_B;
                dec.sext      = imm_b;
                dec.is_branch = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_EQ;
                    3'b001:  dec.alu_op = ALU_NE;
                    3'b100:  dec.alu_op = ALU_LT;
                    3'b101:  dec.alu_op = ALU_GE;
                    3'b110:  dec.alu_op = ALU_LTU;
                    3'b111:  dec.alu_op = ALU_GEU;
                    default: legal      = 1'b0;
                endcase
            end
            OPC_LUI: begin
                // Execute shifts this by a forced operand of 12.
                dec.inst_type = INST_U;
                dec.alu_op    = ALU_SLL;
                dec.sext      = {12'd0, inst[31:12]};
                writes        = 1'b1;
            end
            OPC_JAL: begin
                dec.inst_type = INST_J;
                dec.sext      = imm_j;
                dec.is_jal    = 1'b1;
                writes        = 1'b1;
            end
            OPC_JALR: begin
                dec.inst_type = INST_I;
                dec.sext      = imm_i;
                dec.is_jalr   = 1'b1;
                writes        = 1'b1;
                legal         = (funct3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec           = '0;
            dec.rs1       = inst[19:15];
            dec.rs2       = inst[24:20];
            dec.rd        = inst[11:7];
            dec.illegal   = 1'b1;
        end
        dec.rd_we = writes && legal && (inst[11:7] != 5'd0);
    end

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: decodes fetch instructions and holds one bundle
// for execute behind a valid/ready handshake with stall and flush.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [2:0]      inst_type,
    output logic [3:0]      alu_op_type,
    output logic [31:0]     sext_out,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic            rd_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic [2:0]      mem_size,
    output logic            is_branch,
    output logic            is_jal,
    output logic            is_jalr,
    output logic            illegal_inst
);

    dec_t            dec_p0;
    dec_t            dec_p1;
    logic [XLEN-1:0] pc_p1;
    logic            vld_p1;
    logic            load_p0;

    // ---- stage p0: combinational decode of the incoming word
    id_decode u_decode (
        .inst (if_inst),
        .dec  (dec_p0)
    );

    assign if_ready = !vld_p1 || ex_ready;
    assign load_p0  = if_valid && if_ready && !flush;

    // Valid tracking: flush wins, then load, then drain on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (load_p0) begin
            vld_p1 <= 1'b1;
        end else if (ex_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Bundle register: only written on an accepted instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_p1 <= '0;
            pc_p1  <= RESET_PC;
        end else if (load_p0) begin
            dec_p1 <= dec_p0;
            pc_p1  <= if_pc;
        end
    end

    // ---- stage p1: registered outputs toward execute
    assign id_valid     = vld_p1;
    assign id_pc        = pc_p1;
    assign inst_type    = dec_p1.inst_type;
    assign alu_op_type  = dec_p1.alu_op;
    assign sext_out     = dec_p1.sext;
    assign rs1_addr     = dec_p1.rs1;
    assign rs2_addr     = dec_p1.rs2;
    assign rd_addr      = dec_p1.rd;
    assign rd_we        = dec_p1.rd_we;
    assign mem_re       = dec_p1.mem_re;
    assign mem_we       = dec_p1.mem_we;
    assign mem_size     = dec_p1.mem_size;
    assign is_branch    = dec_p1.is_branch;
    assign is_jal       = dec_p1.is_jal;
    assign is_jalr      = dec_p1.is_jalr;
    assign illegal_inst = dec_p1.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: expected bundles queued on accept, compared on consume.
module tb_id_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_valid;
    logic        ex_ready;
    logic [31:0] id_pc;
    logic [2:0]  inst_type;
    logic [3:0]  alu_op_type;
    logic [31:0] sext_out;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we, mem_re, mem_we;
    logic [2:0]  mem_size;
    logic        is_branch, is_jal, is_jalr, illegal_inst;

    id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .id_valid(id_valid), .ex_ready(ex_ready), .id_pc(id_pc),
        .inst_type(inst_type), .alu_op_type(alu_op_type), .sext_out(sext_out),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rd_we(rd_we), .mem_re(mem_re), .mem_we(mem_we), .mem_size(mem_size),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .illegal_inst(illegal_inst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  ty;
        logic [3:0]  alu;
        logic [31:0] sx;
        logic [4:0]  rs1, rs2, rd;
        logic        we, re, mwe;
        logic [2:0]  msz;
        logic        br, jal, jalr, ill;
    } exp_t;

    exp_t        q[$];
    exp_t        none;
    int          total = 0;
    int          bad = 0;
    logic [31:0] pc_ctr;
    logic [31:0] snap_pc, snap_sx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] inst, input logic [2:0] ty,
                                input logic [3:0] alu, input logic [31:0] sx,
                                input logic we, input logic re, input logic mwe,
                                input logic [2:0] msz, input logic br,
                                input logic jal, input logic jalr, input logic ill);
        exp_t e;
        e = '0;
        e.ty = ty; e.alu = alu; e.sx = sx;
        e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
        e.we = we; e.re = re; e.mwe = mwe; e.msz = msz;
        e.br = br; e.jal = jal; e.jalr = jalr; e.ill = ill;
        return e;
    endfunction

    task automatic cmp(input exp_t e);
        chk("pc", id_pc, e.pc);
        chk("rs1", 32'(rs1_addr), 32'(e.rs1));
        chk("rs2", 32'(rs2_addr), 32'(e.rs2));
        chk("rd", 32'(rd_addr), 32'(e.rd));
        chk("rd_we", 32'(rd_we), 32'(e.we));
        chk("mem_re", 32'(mem_re), 32'(e.re));
        chk("mem_we", 32'(mem_we), 32'(e.mwe));
        chk("is_branch", 32'(is_branch), 32'(e.br));
        chk("is_jal", 32'(is_jal), 32'(e.jal));
        chk("is_jalr", 32'(is_jalr), 32'(e.jalr));
        chk("illegal", 32'(illegal_inst), 32'(e.ill));
        if (!e.ill) begin
            chk("inst_type", 32'(inst_type), 32'(e.ty));
            chk("alu_op", 32'(alu_op_type), 32'(e.alu));
            chk("sext", sext_out, e.sx);
            if (e.re || e.mwe) chk("mem_size", 32'(mem_size), 32'(e.msz));
        end
    endtask

    // One cycle: drive at negedge, score the held bundle, queue the accepted one.
    task automatic step(input logic v, input logic [31:0] inst, input exp_t e,
                        input logic er, input logic fl);
        exp_t tmp;
        if_valid = v; if_inst = inst; if_pc = pc_ctr; ex_ready = er; flush = fl;
        #1;
        if (id_valid && fl) begin
            if (q.size() > 0) tmp = q.pop_front();
        end else if (id_valid && er) begin
            if (q.size() == 0) chk("underflow", 32'd1, 32'd0);
            else cmp(q.pop_front());
        end
        if (v && if_ready && !fl) begin
            e.pc = pc_ctr;
            q.push_back(e);
            pc_ctr += 32'd4;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        none = '0;
        pc_ctr = 32'h100;
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0; ex_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_vld", 32'(id_valid), 32'd0);
        chk("rst_pc", id_pc, RST_PC);
        chk("rst_alu", 32'(alu_op_type), 32'd0);
        chk("rst_type", 32'(inst_type), 32'd0);
        chk("rst_sext", sext_out, 32'd0);
        chk("rst_rdwe", 32'(rd_we), 32'd0);
        chk("rst_ready", 32'(if_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back stream with execute always ready.
        step(1, 32'h00500093, mk(32'h00500093, 3'd1, 4'd0, 32'd5, 1, 0, 0, 3'd0, 0, 0, 0, 0), 1, 0);
        chk("lat_vld", 32'(id_valid), 32'd1);
        step(1, 32'h12345137, mk(32'h12345137, 3'd4, 4'd5, 32'h00012345, 1, 0, 0, 3'd0, 0, 0, 0, 0), 1, 0);
        step(1, 32'h402081B3, mk(32'h402081B3, 3'd0, 4'd1, 32'd0, 1, 0, 0, 3'd0, 0, 0, 0, 0), 1, 0);
        chk("flow_vld", 32'(id_valid), 32'd1);
        chk("flow_ready", 32'(if_ready), 32'd1);
        step(1, 32'h00208463, mk(32'h00208463, 3'd3, 4'd8, 32'd8, 0, 0, 0, 3'd0, 1, 0, 0, 0), 1, 0);
        step(1, 32'h0020A223, mk(32'h0020A223, 3'd2, 4'd0, 32'd4, 0, 0, 1, 3'd2, 0, 0, 0, 0), 1, 0);
        step(1, 32'hFFC0A283, mk(32'hFFC0A283, 3'd1, 4'd0, 32'hFFFFFFFC, 1, 1, 0, 3'd2, 0, 0, 0, 0), 1, 0);

        // Stall three cycles with fetch offering the next instruction.
        snap_pc = id_pc; snap_sx = sext_out;
        for (int i = 0; i < 3; i++) begin
            step(1, 32'hFF9FF0EF, none, 0, 0);
            chk("stall_ready", 32'(if_ready), 32'd0);
            chk("stall_vld", 32'(id_valid), 32'd1);
            chk("stall_pc", id_pc, snap_pc);
            chk("stall_sext", sext_out, snap_sx);
        end
        step(1, 32'hFF9FF0EF, mk(32'hFF9FF0EF, 3'd5, 4'd0, 32'hFFFFFFF8, 1, 0, 0, 3'd0, 0, 1, 0, 0), 1, 0);
        step(1, 32'h00008067, mk(32'h00008067, 3'd1, 4'd0, 32'd0, 0, 0, 0, 3'd0, 0, 0, 1, 0), 1, 0);
        step(1, 32'h4030D213, mk(32'h4030D213, 3'd1, 4'd7, 32'd3, 1, 0, 0, 3'd0, 0, 0, 0, 0), 1, 0);
        step(1, 32'hFE20FEE3, mk(32'hFE20FEE3, 3'd3, 4'd13, 32'hFFFFFFFC, 0, 0, 0, 3'd0, 1, 0, 0, 0), 1, 0);
        step(1, 32'hFFF0B313, mk(32'hFFF0B313, 3'd1, 4'd12, 32'hFFFFFFFF, 1, 0, 0, 3'd0, 0, 0, 0, 0), 1, 0);
        step(1, 32'hFFFFFFFF, mk(32'hFFFFFFFF, 3'd0, 4'd0, 32'd0, 0, 0, 0, 3'd0, 0, 0, 0, 1), 1, 0);
        chk("ill_vld", 32'(id_valid), 32'd1);
        step(1, 32'h0210D093, mk(32'h0210D093, 3'd0, 4'd0, 32'd0, 0, 0, 0, 3'd0, 0, 0, 0, 1), 1, 0);
        step(0, 32'h0, none, 1, 0);

        // Drain: valid falls, data holds.
        chk("drain_vld", 32'(id_valid), 32'd0);
        step(0, 32'h0, none, 1, 0);
        chk("drain_pc", id_pc, pc_ctr - 32'd4);

        // Flush with a held and an incoming instruction.
        step(1, 32'h00500093, mk(32'h00500093, 3'd1, 4'd0, 32'd5, 1, 0, 0, 3'd0, 0, 0, 0, 0), 1, 0);
        step(1, 32'h12345137, none, 1, 1);
        chk("flush_vld", 32'(id_valid), 32'd0);

        // Flush during a stall.
        step(1, 32'h00500093, mk(32'h00500093, 3'd1, 4'd0, 32'd5, 1, 0, 0, 3'd0, 0, 0, 0, 0), 1, 0);
        step(1, 32'h12345137, none, 0, 1);
        chk("flush_stall_vld", 32'(id_valid), 32'd0);
        step(1, 32'h402081B3, mk(32'h402081B3, 3'd0, 4'd1, 32'd0, 1, 0, 0, 3'd0, 0, 0, 0, 0), 1, 0);
        step(0, 32'h0, none, 1, 0);
        chk("q_empty", 32'(q.size()), 32'd0);

        // Asynchronous reset while a bundle is held.
        step(1, 32'h00500093, mk(32'h00500093, 3'd1, 4'd0, 32'd5, 1, 0, 0, 3'd0, 0, 0, 0, 0), 1, 0);
        chk("pre_rst_vld", 32'(id_valid), 32'd1);
        if_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_vld", 32'(id_valid), 32'd0);
        chk("async_rst_pc", id_pc, RST_PC);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
